tt_um_pin_sequencer: RTL and testbench

//  Self-contained TinyTapeout user project: a pattern sequencer and signature checker on uio pins.

---
 rtl/tt_um_pin_sequencer_if.sv | 19 +
 rtl/tt_um_pin_sequencer.sv | 175 +++++++++++++++++
 tb/tb_tt_um_pin_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/tt_um_pin_sequencer_if.sv
// Pin bundle of the pin sequencer: the TinyTapeout user pins plus the design-select enable.
interface tt_um_pin_sequencer_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_pin_sequencer.sv
// Pattern sequencer and signature checker: nibble-loaded pattern memory replayed on the uio pins,
// with the sampled uio inputs folded into an 8-bit MISR once per step.
module tt_um_pin_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    tt_um_pin_sequencer_if.slave bus
);
    localparam int         IDX_W   = $clog2(DEPTH);
    localparam logic [7:0] MASK    = 8'((16'd1 << WIDTH) - 16'd1);
    localparam logic [3:0] DEPTH_P = 4'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [1:0]       r_sync;
    logic             r_strobePrev;
    logic [3:0]       r_stage;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [3:0]       r_wptr;
    logic [3:0]       r_rate;
    logic [3:0]       r_stepRate;
    logic [3:0]       r_phase;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_sig;
    logic             r_done;
    logic             r_ovf;
    logic             r_loop;
    logic             r_view;

    state_t     w_nextState;
    logic       w_start;
    logic       w_stopCmd;
    logic       w_cmdFire;
    logic [1:0] w_cmd;
    logic [3:0] w_data;
    logic       w_isLoadLo;
    logic       w_isLoadHi;
    logic       w_isCtrl;
    logic       w_isRate;
    logic       w_stepEnd;
    logic       w_lastIdx;
    logic [7:0] w_loadByte;
    logic [7:0] w_sigNext;

    // The command fires one edge after the synchronised strobe is seen high, i.e. the 3rd edge.
    assign w_cmdFire  = bus.ena & r_sync[1] & ~r_strobePrev;
    assign w_cmd      = bus.ui_in[6:5];
    assign w_data     = bus.ui_in[3:0];
    assign w_isLoadLo = w_cmdFire && (w_cmd == 2'd0);
    assign w_isLoadHi = w_cmdFire && (w_cmd == 2'd1);
    assign w_isCtrl   = w_cmdFire && (w_cmd == 2'd2);
    assign w_isRate   = w_cmdFire && (w_cmd == 2'd3);

    assign w_stepEnd  = (r_state == RUN) && (r_phase == r_stepRate);
    assign w_lastIdx  = (4'(r_idx) == (r_wptr - 4'd1));
    assign w_loadByte = {w_data, r_stage};
    assign w_sigNext  = {r_sig[6:0], 1'b0} ^ (r_sig[7] ? 8'h71 : 8'h00) ^ (bus.uio_in & MASK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else if (bus.ena) begin
            r_state <= w_nextState;
        end
    end

    // Clear always forces IDLE; a stop command pre-empts any step completing on the same edge.
    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_stopCmd   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (w_isCtrl && w_data[2]) begin
                    w_nextState = IDLE;
                end else if (w_isCtrl && w_data[0] && (r_wptr != 4'd0)) begin
                    w_nextState = RUN;
                    w_start     = 1'b1;
                end
            end
            RUN: begin
                if (w_isCtrl && (w_data[2] || !w_data[0])) begin
                    w_nextState = IDLE;
                    w_stopCmd   = 1'b1;
                end else if (w_stepEnd && w_lastIdx && !r_loop) begin
                    w_nextState = DONE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync       <= 2'b00;
            r_strobePrev <= 1'b0;
            r_stage      <= 4'd0;
            r_wptr       <= 4'd0;
            r_rate       <= 4'd0;
            r_stepRate   <= 4'd0;
            r_phase      <= 4'd0;
            r_idx        <= '0;
            r_sig        <= 8'd0;
            r_done       <= 1'b0;
            r_ovf        <= 1'b0;
            r_loop       <= 1'b0;
            r_view       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.ena) begin
            r_sync       <= {r_sync[0], bus.ui_in[7]};
            r_strobePrev <= r_sync[1];

            if (w_isLoadLo) begin
                r_stage <= w_data;
            end
            if (w_isLoadHi && (r_state != RUN)) begin
                if (r_wptr == DEPTH_P) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_mem[r_wptr[IDX_W-1:0]] <= w_loadByte[WIDTH-1:0];
                    r_wptr                   <= r_wptr + 4'd1;
                end
            end
            if (w_isRate) begin
                r_rate <= w_data;
            end
            if (w_isCtrl) begin
                r_loop <= w_data[1];
                r_view <= w_data[3];
            end

            // A new rate is only picked up when a step begins.
            if ((r_state == RUN) && !w_stopCmd) begin
                if (w_stepEnd) begin
                    r_sig      <= w_sigNext;
                    r_phase    <= 4'd0;
                    r_stepRate <= r_rate;
                    if (w_lastIdx) begin
                        r_idx <= '0;
                        if (!r_loop) begin
                            r_done <= 1'b1;
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end else begin
                    r_phase <= r_phase + 4'd1;
                end
            end

            if (w_start) begin
                r_idx      <= '0;
                r_phase    <= 4'd0;
                r_stepRate <= r_rate;
                r_done     <= 1'b0;
            end

            if (w_isCtrl && w_data[2]) begin
                r_wptr <= 4'd0;
                r_sig  <= 8'd0;
                r_done <= 1'b0;
                r_ovf  <= 1'b0;
            end
        end
    end

    assign bus.uio_out = (r_state == RUN) ? 8'(r_mem[r_idx]) : 8'h00;
    assign bus.uio_oe  = (r_state == RUN) ? MASK : 8'h00;
    assign bus.uo_out  = r_view ? {(r_state == RUN), r_done, r_ovf, 1'b0, r_wptr} : r_sig;
endmodule

// File: tb/tb_tt_um_pin_sequencer.sv
// Bench for the pin sequencer: directed scenarios plus random command traffic, all checked
// every cycle against a command-level model of the sequencer.
module tb_tt_um_pin_sequencer;
    localparam int         WIDTH = 8;
    localparam int         DEPTH = 8;
    localparam logic [7:0] MASK  = 8'hFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    tt_um_pin_sequencer_if bus();

    tt_um_pin_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.uio_in = bus.uio_out & bus.uio_oe;

    // Model state: patterns, pointer count, playback position and flags.
    bit [7:0] mMem [DEPTH];
    int       mCount, mPeriod, mTick, mIdx;
    bit [3:0] mStage, mRate;
    bit [7:0] mSig;
    bit       mDone, mOvf, mLoop, mView, mRunning;
    bit       p1, p2, p3;

    function automatic logic [7:0] misr(input logic [7:0] s, input logic [7:0] x);
        return 8'(s << 1) ^ (s[7] ? 8'h71 : 8'h00) ^ x;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) mMem[i] = 8'h00;
        mCount = 0; mPeriod = 1; mTick = 0; mIdx = 0;
        mStage = 4'd0; mRate = 4'd0; mSig = 8'h00;
        mDone = 0; mOvf = 0; mLoop = 0; mView = 0; mRunning = 0;
        p1 = 0; p2 = 0; p3 = 0;
    endtask

    task automatic modelEdge();
        bit       fire, wasRunning, stopNow;
        bit [1:0] cmd;
        bit [3:0] data;
        fire = p2 && !p3;
        p3 = p2; p2 = p1; p1 = bus.ui_in[7];
        cmd  = bus.ui_in[6:5];
        data = bus.ui_in[3:0];
        wasRunning = mRunning;
        stopNow = fire && (cmd == 2'd2) && wasRunning && (data[2] || !data[0]);
        if (wasRunning && !stopNow) begin
            mTick++;
            if (mTick == mPeriod) begin
                mSig = misr(mSig, mMem[mIdx] & MASK);
                mTick = 0;
                mPeriod = int'(mRate) + 1;
                if (mIdx == mCount - 1) begin
                    mIdx = 0;
                    if (!mLoop) begin
                        mRunning = 0;
                        mDone = 1;
                    end
                end else begin
                    mIdx++;
                end
            end
        end
        if (fire) begin
            case (cmd)
                2'd0: mStage = data;
                2'd1: if (!wasRunning) begin
                    if (mCount == DEPTH) mOvf = 1;
                    else begin
                        mMem[mCount] = {data, mStage} & MASK;
                        mCount++;
                    end
                end
                2'd2: begin
                    mLoop = data[1];
                    mView = data[3];
                    if (data[2]) begin
                        mCount = 0; mSig = 8'h00; mDone = 0; mOvf = 0; mRunning = 0;
                    end else if (data[0] && !wasRunning && mCount > 0) begin
                        mRunning = 1; mIdx = 0; mTick = 0; mPeriod = int'(mRate) + 1; mDone = 0;
                    end else if (!data[0] && wasRunning) begin
                        mRunning = 0;
                    end
                end
                default: mRate = data;
            endcase
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) modelReset();
        else if (bus.ena) modelEdge();
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("uio_out", bus.uio_out, mRunning ? mMem[mIdx] : 8'h00);
            checkOutput("uio_oe", bus.uio_oe, mRunning ? MASK : 8'h00);
            checkOutput("uo_out", bus.uo_out,
                        mView ? {mRunning, mDone, mOvf, 1'b0, 4'(mCount)} : mSig);
        end
    end

    task automatic applyStimulus(input logic [1:0] cmd, input logic [3:0] data);
        bus.ui_in = {1'b1, cmd, 1'b0, data};
        repeat (4) @(negedge clk);
        bus.ui_in[7] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [1:0] rc;
        logic [3:0] rd;
        bus.ena   = 1'b1;
        bus.ui_in = 8'h00;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset uo_out", bus.uo_out, 8'h00);
        checkOutput("reset uio_out", bus.uio_out, 8'h00);
        checkOutput("reset uio_oe", bus.uio_oe, 8'h00);
        rst_n = 1'b1;

        $display("[TB] scenario 1: two patterns at rate 0");
        applyStimulus(2'd0, 4'h5); applyStimulus(2'd1, 4'hA);
        applyStimulus(2'd0, 4'hC); applyStimulus(2'd1, 4'h3);
        applyStimulus(2'd3, 4'h0);
        bus.ui_in = {1'b1, 2'd2, 1'b0, 4'b0001};
        repeat (3) @(negedge clk);
        checkOutput("t1 step0 uio_out", bus.uio_out, 8'hA5);
        checkOutput("t1 step0 uio_oe", bus.uio_oe, 8'hFF);
        @(negedge clk);
        checkOutput("t1 step1 uio_out", bus.uio_out, 8'h3C);
        bus.ui_in[7] = 1'b0;
        @(negedge clk);
        checkOutput("t1 done uio_oe", bus.uio_oe, 8'h00);
        checkOutput("t1 sig", bus.uo_out, 8'h07);
        repeat (3) @(negedge clk);

        $display("[TB] scenario 2: two patterns at rate 3");
        applyStimulus(2'd2, 4'b0100);
        applyStimulus(2'd0, 4'h5); applyStimulus(2'd1, 4'hA);
        applyStimulus(2'd0, 4'hC); applyStimulus(2'd1, 4'h3);
        applyStimulus(2'd3, 4'd3);
        applyStimulus(2'd2, 4'b0001);
        repeat (6) @(negedge clk);
        checkOutput("t2 sig", bus.uo_out, 8'h07);
        applyStimulus(2'd2, 4'b1000);
        checkOutput("t2 status", bus.uo_out, 8'h42);

        $display("[TB] scenario 3: overfill the pattern memory");
        applyStimulus(2'd2, 4'b1100);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(2'd0, 4'(i));
            applyStimulus(2'd1, 4'(i + 1));
        end
        checkOutput("t3 status", bus.uo_out, 8'h28);
        applyStimulus(2'd2, 4'b0001);
        repeat (32) @(negedge clk);

        $display("[TB] scenario 4: looping run then stop");
        applyStimulus(2'd2, 4'b0011);
        repeat (36) @(negedge clk);
        applyStimulus(2'd2, 4'b0000);

        $display("[TB] scenario 5: enable freeze mid-run");
        applyStimulus(2'd2, 4'b0011);
        repeat (5) @(negedge clk);
        bus.ena = 1'b0;
        repeat (5) @(negedge clk);
        bus.ena = 1'b1;
        repeat (20) @(negedge clk);
        applyStimulus(2'd2, 4'b0000);

        $display("[TB] scenario 6: run with clear, then reset mid-run");
        applyStimulus(2'd2, 4'b1101);
        checkOutput("t6 status", bus.uo_out, 8'h00);
        checkOutput("t6 uio_oe", bus.uio_oe, 8'h00);
        applyStimulus(2'd0, 4'h1); applyStimulus(2'd1, 4'h8);
        applyStimulus(2'd0, 4'h2); applyStimulus(2'd1, 4'h4);
        applyStimulus(2'd2, 4'b0011);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6 reset uo_out", bus.uo_out, 8'h00);
        checkOutput("t6 reset uio_out", bus.uio_out, 8'h00);
        checkOutput("t6 reset uio_oe", bus.uio_oe, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] random command traffic");
        repeat (150) begin
            rc = 2'($urandom_range(0, 3));
            rd = 4'($urandom);
            if (rc == 2'd2) begin
                if ($urandom_range(0, 3) != 0) rd[2] = 1'b0;
                if ($urandom_range(0, 1) != 0) rd[0] = 1'b1;
            end
            if (rc == 2'd3) begin
                if (mRunning) rc = 2'd0;
                else rd = 4'($urandom_range(0, 3));
            end
            applyStimulus(rc, rd);
            if ($urandom_range(0, 7) == 0) begin
                bus.ena = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                bus.ena = 1'b1;
            end
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
